// File: rtl/mc_cpu_pkg.sv
// Purpose : shared constants and types for the multi-cycle MIPS-subset core.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: opcode/funct codes, ALUControl codes, FSM state enum, mux selects.
package mc_cpu_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [5:0] op_j     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] fn_add = 6'b100000;
  localparam logic [5:0] fn_sub = 6'b100010;
  localparam logic [5:0] fn_and = 6'b100100;
  localparam logic [5:0] fn_or  = 6'b100101;
  localparam logic [5:0] fn_slt = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] alu_add = 3'b010;
  localparam logic [2:0] alu_sub = 3'b110;
  localparam logic [2:0] alu_and = 3'b000;
  localparam logic [2:0] alu_or  = 3'b001;
  localparam logic [2:0] alu_slt = 3'b111;

  // Controller states; the encodings are architecturally visible on the state port.
  typedef enum logic [3:0] {
    st_fetch    = 4'd0,
    st_decode   = 4'd1,
    st_memadr   = 4'd2,
    st_memrd    = 4'd3,
    st_memwb    = 4'd4,
    st_memwr    = 4'd5,
    st_execute  = 4'd6,
    st_aluwb    = 4'd7,
    st_branch   = 4'd8,
    st_addiexec = 4'd9,
    st_addiwb   = 4'd10,
    st_jump     = 4'd11
  } state_t;

  // ALU second-operand select
  typedef enum logic [1:0] {
    srcb_reg = 2'd0,
    srcb_one = 2'd1,
    srcb_imm = 2'd2
  } srcb_t;

  // PC next-value select
  typedef enum logic [1:0] {
    pc_alu    = 2'd0,
    pc_aluout = 2'd1,
    pc_jump   = 2'd2
  } pcsrc_t;

  // R-type funct to ALUControl; unknown functs execute as add.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    case (funct)
      fn_add:  return alu_add;
      fn_sub:  return alu_sub;
      fn_and:  return alu_and;
      fn_or:   return alu_or;
      fn_slt:  return alu_slt;
      default: return alu_add;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Purpose : combinational ALU (add/sub/and/or/signed slt) with zero flag.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of inputs.
// Ports   : op1, op2 operands; sel ALUControl code; out result; zero = (out == 0).
module mc_alu
  import mc_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  always_comb begin
    out = '0;
    case (sel)
      alu_add: out = op1 + op2;
      alu_sub: out = op1 - op2;
      alu_and: out = op1 & op2;
      alu_or:  out = op1 | op2;
      alu_slt: out = WIDTH'($signed(op1) < $signed(op2));
      default: out = op1 + op2;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/mc_cpu_core.sv
// Purpose : multi-cycle word-addressed MIPS-subset core, shared instr/data memory.
// Latency : 3-5 clocks per instruction (2 for unrecognised opcodes).
// Backpressure: none; self-contained, runs every clock once out of reset.
// Ports   : clk; rst synchronous active-low; state = current controller state.
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    MEM_WORDS = 32,
  parameter string INIT_FILE = "program.mem"
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] state
);

  localparam int AW = $clog2(MEM_WORDS);

  // The program image named by INIT_FILE is placed into mem by the platform's
  // memory initialisation flow; the core never reloads or clears it.
  if (INIT_FILE == "") begin : g_no_image
    $error("mc_cpu_core: INIT_FILE must name a memory image");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mc_cpu_core: MEM_WORDS must be a power of two");
  end

  logic [WIDTH-1:0] mem [MEM_WORDS];
  logic [WIDTH-1:0] rf  [32];

  logic [WIDTH-1:0] pc, ir, data, a, b, aluout;
  state_t           cur;

  // Control, decoded from the registered state
  logic       irwrite, pcwrite, branch, iord, memwrite;
  logic       regwrite, regdst, memtoreg, srca_pc;
  srcb_t      srcb;
  pcsrc_t     pcsrc;
  logic [2:0] alusel;

  // Datapath nets
  logic [WIDTH-1:0] signimm, jtarget, rd1, rd2, alu_a, alu_b, alu_y, pc_next, wd;
  logic [AW-1:0]    idx;
  logic [4:0]       wa;
  logic             zero, pc_en;

  assign state = cur;

  assign signimm = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign jtarget = {{(WIDTH-26){1'b0}}, ir[25:0]};

  // Memory aliases modulo MEM_WORDS: only the low address bits are used.
  assign idx = iord ? aluout[AW-1:0] : pc[AW-1:0];

  assign rd1 = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
  assign rd2 = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];

  assign wa = regdst ? ir[15:11] : ir[20:16];
  assign wd = memtoreg ? data : aluout;

  always_comb begin
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    srca_pc  = 1'b1;
    srcb     = srcb_reg;
    alusel   = alu_add;
    pcsrc    = pc_alu;
    case (cur)
      st_fetch: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        srcb    = srcb_one;
      end
      // PC is already incremented here, so PC + SignImm is the branch target.
      st_decode:   srcb = srcb_imm;
      st_memadr: begin
        srca_pc = 1'b0;
        srcb    = srcb_imm;
      end
      st_memrd:    iord = 1'b1;
      st_memwb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      st_memwr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      st_execute: begin
        srca_pc = 1'b0;
        alusel  = alu_for_funct(ir[5:0]);
      end
      st_aluwb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      st_branch: begin
        srca_pc = 1'b0;
        alusel  = alu_sub;
        branch  = 1'b1;
        pcsrc   = pc_aluout;
      end
      st_addiexec: begin
        srca_pc = 1'b0;
        srcb    = srcb_imm;
      end
      st_addiwb:   regwrite = 1'b1;
      st_jump: begin
        pcwrite = 1'b1;
        pcsrc   = pc_jump;
      end
      default: ;
    endcase
  end

  assign alu_a = srca_pc ? pc : a;

  always_comb begin
    case (srcb)
      srcb_one: alu_b = WIDTH'(1);
      srcb_imm: alu_b = signimm;
      default:  alu_b = b;
    endcase
  end

  mc_alu #(.WIDTH(WIDTH)) u_alu (
    .op1  (alu_a),
    .op2  (alu_b),
    .sel  (alusel),
    .out  (alu_y),
    .zero (zero)
  );

  assign pc_en = pcwrite | (branch & zero);

  always_comb begin
    case (pcsrc)
      pc_aluout: pc_next = aluout;
      pc_jump:   pc_next = jtarget;
      default:   pc_next = alu_y;
    endcase
  end

  // Controller
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur <= st_fetch;
    end else begin
      case (cur)
        st_fetch:  cur <= st_decode;
        st_decode: begin
          case (ir[31:26])
            op_lw, op_sw: cur <= st_memadr;
            op_rtype:     cur <= st_execute;
            op_beq:       cur <= st_branch;
            op_addi:      cur <= st_addiexec;
            op_j:         cur <= st_jump;
            default:      cur <= st_fetch;
          endcase
        end
        st_memadr:   cur <= (ir[31:26] == op_lw) ? st_memrd : st_memwr;
        st_memrd:    cur <= st_memwb;
        st_execute:  cur <= st_aluwb;
        st_addiexec: cur <= st_addiwb;
        default:     cur <= st_fetch;
      endcase
    end
  end

  // Architectural and pipeline-style holding registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= '0;
      ir     <= '0;
      data   <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pc_en)   pc <= pc_next;
      if (irwrite) ir <= mem[idx];
      data   <= mem[idx];
      a      <= rd1;
      b      <= rd2;
      aluout <= alu_y;
    end
  end

  // Register file: old value is read in the cycle of a write; r0 is never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite && wa != 5'd0) begin
      rf[wa] <= wd;
    end
  end

  // Memory is not cleared by reset; a reset edge suppresses any pending store.
  always_ff @(posedge clk) begin
    if (rst && memwrite) mem[idx] <= b;
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
module tb_mc_cpu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;

  // Reference machine state
  logic [31:0] m_mem [32];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc;

  mc_cpu_core #(
    .WIDTH     (32),
    .MEM_WORDS (32),
    .INIT_FILE ("program.mem")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .state (state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic load(input logic [4:0] idx, input logic [31:0] w);
    dut.mem[idx] <= w;
    m_mem[idx] = w;
  endtask

  // Called at a falling edge; holds reset for the given number of rising edges.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_ir", dut.ir, 32'd0);
    chk("rst_data", dut.data, 32'd0);
    chk("rst_a", dut.a, 32'd0);
    chk("rst_b", dut.b, 32'd0);
    chk("rst_aluout", dut.aluout, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_r%0d", i), dut.rf[i], 32'd0);
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    rst = 1'b1;
  endtask

  // Instruction-level reference: executes one instruction on the model, then
  // checks the DUT's state trace cycle by cycle and its architectural state after.
  task automatic run_instr(input string tag);
    logic [31:0] ins, va, vb, imm, addr, npc, r;
    logic [4:0]  rs, rt, rd;
    int          exp_st[$];
    ins  = m_mem[m_pc[4:0]];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    va   = m_rf[rs];
    vb   = m_rf[rt];
    imm  = {{16{ins[15]}}, ins[15:0]};
    addr = va + imm;
    npc  = m_pc + 32'd1;
    case (ins[31:26])
      6'h00: begin
        exp_st = '{0, 1, 6, 7};
        case (ins[5:0])
          6'h22:   r = va - vb;
          6'h24:   r = va & vb;
          6'h25:   r = va | vb;
          6'h2a:   r = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: r = va + vb;
        endcase
        if (rd != 5'd0) m_rf[rd] = r;
      end
      6'h23: begin
        exp_st = '{0, 1, 2, 3, 4};
        if (rt != 5'd0) m_rf[rt] = m_mem[addr[4:0]];
      end
      6'h2b: begin
        exp_st = '{0, 1, 2, 5};
        m_mem[addr[4:0]] = vb;
      end
      6'h04: begin
        exp_st = '{0, 1, 8};
        if (va == vb) npc = m_pc + 32'd1 + imm;
      end
      6'h08: begin
        exp_st = '{0, 1, 9, 10};
        if (rt != 5'd0) m_rf[rt] = va + imm;
      end
      6'h02: begin
        exp_st = '{0, 1, 11};
        npc = {6'b0, ins[25:0]};
      end
      default: exp_st = '{0, 1};
    endcase
    m_pc = npc;
    foreach (exp_st[k]) begin
      chk($sformatf("%s_state%0d", tag, k), 32'(state), exp_st[k]);
      @(negedge clk);
    end
    chk($sformatf("%s_pc", tag), dut.pc, m_pc);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.rf[i], m_rf[i]);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_mem%0d", tag, i), dut.mem[i], m_mem[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom_range(0, 40)) - 16'd12;
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2a;
      default: fn = 6'($urandom);
    endcase
    case ($urandom_range(0, 10))
      0, 1, 2: return enc_r(rs, rt, rd, fn);
      3:       return enc_i(6'h08, rs, rt, imm);
      4:       return enc_i(6'h08, rs, rt, 16'($urandom));
      5:       return enc_i(6'h23, rs, rt, imm);
      6:       return enc_i(6'h2b, rs, rt, imm);
      7, 8:    return enc_i(6'h04, rs, rt, imm);
      9:       return {6'h02, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Directed program
    for (int i = 0; i < 32; i++) load(5'(i), 32'd0);
    load(5'd0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));       // addi r1,r0,5
    load(5'd1,  enc_i(6'h08, 5'd0, 5'd2, 16'd7));       // addi r2,r0,7
    load(5'd2,  enc_r(5'd1, 5'd2, 5'd3, 6'h20));        // add r3,r1,r2
    load(5'd3,  enc_i(6'h04, 5'd1, 5'd1, 16'd2));       // beq r1,r1,+2
    load(5'd4,  enc_i(6'h08, 5'd0, 5'd7, 16'd1));       // skipped
    load(5'd5,  enc_i(6'h08, 5'd0, 5'd7, 16'd1));       // skipped
    load(5'd6,  enc_i(6'h2b, 5'd0, 5'd3, 16'd20));      // sw r3,20(r0)
    load(5'd7,  enc_i(6'h23, 5'd0, 5'd4, 16'd20));      // lw r4,20(r0)
    load(5'd8,  enc_i(6'h04, 5'd1, 5'd2, 16'd5));       // beq r1,r2 (not taken)
    load(5'd9,  enc_r(5'd1, 5'd2, 5'd5, 6'h22));        // sub r5,r1,r2
    load(5'd10, enc_r(5'd1, 5'd2, 5'd6, 6'h2a));        // slt r6,r1,r2
    load(5'd11, 32'hFC00_0000);                         // undefined opcode
    load(5'd12, {6'h02, 26'd0});                        // j 0
    do_reset(2);

    run_instr("addi1");
    run_instr("addi2");
    run_instr("add");
    chk("tp_r3", dut.rf[3], 32'd12);
    run_instr("beq_t");
    chk("tp_beq_taken_pc", dut.pc, 32'd6);
    run_instr("sw");
    chk("tp_mem20", dut.mem[20], 32'd12);
    run_instr("lw");
    chk("tp_r4", dut.rf[4], 32'd12);
    run_instr("beq_nt");
    chk("tp_beq_nt_pc", dut.pc, 32'd9);
    run_instr("sub");
    chk("tp_sub", dut.rf[5], 32'hFFFF_FFFE);
    run_instr("slt");
    chk("tp_slt", dut.rf[6], 32'd1);
    run_instr("undef");
    run_instr("j0");
    chk("tp_j_pc", dut.pc, 32'd0);
    chk("tp_r7_untouched", dut.rf[7], 32'd0);

    // Reset asserted while a store is in MEMWR must suppress the store
    rst = 1'b0;
    load(5'd0,  enc_i(6'h08, 5'd0, 5'd1, 16'd9));       // addi r1,r0,9
    load(5'd1,  enc_i(6'h2b, 5'd0, 5'd1, 16'd25));      // sw r1,25(r0)
    load(5'd25, 32'hA5A5_A5A5);
    do_reset(2);
    run_instr("mr_addi");
    chk("mr_st0", 32'(state), 32'd0);
    @(negedge clk);
    chk("mr_st1", 32'(state), 32'd1);
    @(negedge clk);
    chk("mr_st2", 32'(state), 32'd2);
    @(negedge clk);
    chk("mr_st5", 32'(state), 32'd5);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_mem25", dut.mem[25], 32'hA5A5_A5A5);
    chk("mr_pc", dut.pc, 32'd0);
    chk("mr_r1", dut.rf[1], 32'd0);

    // Random programs against the instruction-level model
    for (int p = 0; p < 3; p++) begin
      rst = 1'b0;
      for (int i = 0; i < 32; i++) load(5'(i), rand_instr());
      do_reset(2);
      for (int n = 0; n < 120; n++) begin
        if (miscompares > 40) break;
        run_instr($sformatf("rnd%0d_%0d", p, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Multi-cycle, word-addressed 32-bit MIPS-subset processor core: one shared instruction/data memory, a 32×32 register file, an ALU and a 12-state control FSM. It executes one instruction over 3–5 clocks and exposes only the current FSM state for observation. It is a self-contained top level; the program is preloaded into memory.

## Interface
- `WIDTH`, default 32: datapath width.
- `MEM_WORDS`, default 32: memory depth in words.
  - Addressed by `addr[4:0]`.
  - Must be a power of two.
- `INIT_FILE`, default `"program.mem"`: hex image loaded into memory at time 0.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-low.
- `state`, output, 4 bits: current FSM state encoding.

## Operation
- Memory: `MEM_WORDS` × `WIDTH`.
  - Read is combinational.
  - Write is synchronous, when MemWrite is 1.
  - Contents are not affected by reset.
- Addressing is by word. PC increments by 1. Branch and jump targets are word addresses.
- Register file:
  - Read is combinational on `instr[25:21]` and `instr[20:16]`.
  - Write is synchronous on RegWrite. Destination is `instr[15:11]` for R-type, `instr[20:16]` for lw/addi.
  - r0 always reads 0.
- Internal registers: PC, IR (written only on IRWrite), Data, A, B, ALUOut. Data, A, B and ALUOut load every cycle.
- ALUControl encoding:
  - 010 = add
  - 110 = sub
  - 000 = and
  - 001 = or
  - 111 = slt (signed, result 1 or 0)
  - Zero = (result == 0)
- Supported instructions:
  - R-type, opcode 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - lw 100011.
  - sw 101011.
  - beq 000100.
  - addi 001000.
  - j 000010.
- The immediate is sign-extended from 16 bits.
- Jump target is `{6'b0, instr[25:0]}`.
- Branch target is (PC of beq) + 1 + SignImm. It is computed in DECODE as PC + SignImm, because PC has already been incremented.
- FSM states and transitions (encoding in parentheses):
  - FETCH(0): IR←mem[PC], PC←PC+1. Next: DECODE.
  - DECODE(1): ALUOut←PC+SignImm. Next by opcode:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEXEC
    - j → JUMP
    - any other opcode → FETCH (treated as a nop)
  - MEMADR(2): ALUOut←A+SignImm. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD(3): address = ALUOut, Data←mem. Next: MEMWB.
  - MEMWB(4): rt←Data. Next: FETCH.
  - MEMWR(5): mem[ALUOut]←B. Next: FETCH.
  - EXECUTE(6): ALUOut←A op B, where op comes from funct. Next: ALUWB.
  - ALUWB(7): rd←ALUOut. Next: FETCH.
  - BRANCH(8): compute A−B; if Zero, PC←ALUOut. Next: FETCH.
  - ADDIEXEC(9): ALUOut←A+SignImm. Next: ADDIWB.
  - ADDIWB(10): rt←ALUOut. Next: FETCH.
  - JUMP(11): PC←jump target. Next: FETCH.
- An unrecognised funct in an R-type instruction executes as add.

## Timing
- Reset (`rst`=0 at a rising edge):
  - state=FETCH (0), PC=0.
  - IR, A, B, Data, ALUOut and all registers are set to 0.
  - Memory is unchanged.
  - Reset asserted mid-instruction aborts it; no further write is performed.
- The first fetch occurs on the first rising edge with `rst`=1.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unknown opcode: 2
- PC enable = PCWrite | (Branch & Zero).
- PC wraps modulo 2^WIDTH. Memory is indexed by `addr[4:0]` only, so addresses alias modulo `MEM_WORDS`.
- Writes to r0 are discarded.
- A register write and a read of the same register in the same cycle: the read returns the old value.

## Structure
- Shared package `mc_cpu_pkg` holds:
  - opcode and funct constants
  - ALUControl codes
  - FSM state enum (4-bit, encodings above)
- Natural sub-module: `mc_alu`, a combinational ALU with inputs op1, op2, sel[2:0] and outputs out and zero.
- The controller FSM, register file and memory are implemented inline in `mc_cpu_core`.

## Test plan
1. Reset held 2 cycles, then released → state 0 at first edge; sequence 0,1,… begins; PC=0.
2. Memory with addi r1,r0,5 then addi r2,r0,7 then add r3,r1,r2 → after 12 cycles r3=12; state sequence 0,1,9,10 ×2 then 0,1,6,7.
3. sw r3,20(r0) then lw r4,20(r0) → mem[20]=12 after 4 cycles; r4=12 after 5 more cycles.
4. beq r1,r1,+2 at address 3 → next fetch from address 6 (3 cycles). beq r1,r2 with r1≠r2 → next fetch from address 4.
5. j 0 at address 9 → PC=0 after 3 cycles (states 0,1,11). An undefined opcode → states 0,1,0 with no register or memory change.
6. sub and slt with r1=5, r2=7 → sub gives 0xFFFFFFFE and slt gives 1. Reset asserted during MEMWR → mem unchanged, state=0.
